// File: rtl/zoom_out_media_pkg.sv
// Shared definitions for the zoom paths: default frame geometry, zoom-factor
// encodings, FSM state encoding and a helper mapping the zoom factor to log2(N).
package zoom_out_media_pkg;

  localparam int LARGURA = 320;  // source width in pixels
  localparam int ALTURA  = 240;  // source height in pixels
  localparam int AW      = 17;   // memory address width

  localparam logic [1:0] FZ_1X  = 2'b00;
  localparam logic [1:0] FZ_2X  = 2'b01;
  localparam logic [1:0] FZ_4X  = 2'b10;
  localparam logic [1:0] FZ_RES = 2'b11;  // reserved, behaves as 1x

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LEITURA = 3'd1,
    ESPERA  = 3'd2,
    ESCRITA = 3'd3,
    FIM     = 3'd4
  } zoom_estado_t;

  // log2 of the reduction factor N (0, 1 or 2).
  function automatic logic [1:0] fator_para_shift(input logic [1:0] fz);
    case (fz)
      FZ_2X:   return 2'd1;
      FZ_4X:   return 2'd2;
      FZ_RES:  return 2'd0;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/zoom_out_gerador_end.sv
// Address generator for the zoom-out path.
// Produces the source read address (row-major inside each NxN block) and the
// destination write address, using only adders and incremental row bases.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   carga           : start of a frame, clear all position counters
//   passo_leitura   : one block read issued this cycle, advance within block
//   prep_escrita    : next edge enters the write cycle, present the write address
//   prox_pixel      : write cycle, move to the next destination block
//   sh              : log2(N) latched for the frame
//   rd_addr/wr_addr : registered addresses
//   fim_bloco       : current read is the last of the block
//   fim_quadro      : current block is the last of the frame
module zoom_out_gerador_end #(
  parameter int LARGURA = 320,
  parameter int ALTURA  = 240,
  parameter int AW      = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carga,
  input  logic          passo_leitura,
  input  logic          prep_escrita,
  input  logic          prox_pixel,
  input  logic [1:0]    sh,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wr_addr,
  output logic          fim_bloco,
  output logic          fim_quadro
);

  localparam logic [AW-1:0] LARG = AW'(LARGURA);
  localparam logic [AW-1:0] ALT  = AW'(ALTURA);

  logic [1:0]    i_reg, j_reg;
  logic [AW-1:0] xd_reg, yd_reg;
  logic [AW-1:0] row_base_reg;  // first address of the current block row
  logic [AW-1:0] blk_base_reg;  // top-left address of the current block
  logic [AW-1:0] line_reg;      // first address of the current sub-row
  logic [AW-1:0] rd_addr_reg, wr_addr_reg, pix_cnt_reg;

  logic [1:0]    nm1;
  logic [AW-1:0] lw_m1, lh_m1, passo_linha, passo_bloco, prox_base;

  always_comb begin
    nm1 = 2'd0;
    case (sh)
      2'd1:    nm1 = 2'd1;
      2'd2:    nm1 = 2'd3;
      default: nm1 = 2'd0;
    endcase
    lw_m1       = (LARG >> sh) - AW'(1);
    lh_m1       = (ALT >> sh) - AW'(1);
    passo_linha = LARG << sh;        // N source rows
    passo_bloco = AW'(1) << sh;      // N source columns
    prox_base   = (xd_reg == lw_m1) ? (row_base_reg + passo_linha)
                                    : (blk_base_reg + passo_bloco);
  end

  assign fim_bloco  = (i_reg == nm1) && (j_reg == nm1);
  assign fim_quadro = (xd_reg == lw_m1) && (yd_reg == lh_m1);
  assign rd_addr    = rd_addr_reg;
  assign wr_addr    = wr_addr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      i_reg        <= '0;
      j_reg        <= '0;
      xd_reg       <= '0;
      yd_reg       <= '0;
      row_base_reg <= '0;
      blk_base_reg <= '0;
      line_reg     <= '0;
      rd_addr_reg  <= '0;
      wr_addr_reg  <= '0;
      pix_cnt_reg  <= '0;
    end else if (carga) begin
      i_reg        <= '0;
      j_reg        <= '0;
      xd_reg       <= '0;
      yd_reg       <= '0;
      row_base_reg <= '0;
      blk_base_reg <= '0;
      line_reg     <= '0;
      rd_addr_reg  <= '0;
      pix_cnt_reg  <= '0;
    end else begin
      if (passo_leitura && !fim_bloco) begin
        if (i_reg == nm1) begin
          i_reg       <= '0;
          j_reg       <= j_reg + 2'd1;
          line_reg    <= line_reg + LARG;
          rd_addr_reg <= line_reg + LARG;
        end else begin
          i_reg       <= i_reg + 2'd1;
          rd_addr_reg <= rd_addr_reg + AW'(1);
        end
      end
      // Takes effect on the edge into the write cycle, so wr_addr only
      // changes together with wr_en.
      if (prep_escrita) begin
        wr_addr_reg <= pix_cnt_reg;
      end
      if (prox_pixel) begin
        pix_cnt_reg <= pix_cnt_reg + AW'(1);
        // After the last block the read address is left untouched so it keeps
        // the last address actually read.
        if (!fim_quadro) begin
          i_reg        <= '0;
          j_reg        <= '0;
          blk_base_reg <= prox_base;
          line_reg     <= prox_base;
          rd_addr_reg  <= prox_base;
          if (xd_reg == lw_m1) begin
            xd_reg       <= '0;
            yd_reg       <= yd_reg + AW'(1);
            row_base_reg <= prox_base;
          end else begin
            xd_reg <= xd_reg + AW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/zoom_out_media.sv
// Zoom-out by block averaging: each NxN source block (N = 1, 2, 4) is summed
// and truncated into one destination pixel, destination written row-major.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start, fator_zoom  : frame request and zoom factor (sampled on acceptance)
//   rd_en, rd_addr     : source read strobe/address; rd_data one cycle later
//   wr_en, wr_addr, wr_data : destination write
//   busy, done         : frame in progress, one-cycle completion pulse
module zoom_out_media #(
  parameter int LARGURA = zoom_out_media_pkg::LARGURA,
  parameter int ALTURA  = zoom_out_media_pkg::ALTURA,
  parameter int AW      = zoom_out_media_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    fator_zoom,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done
);

  import zoom_out_media_pkg::*;

  zoom_estado_t state_reg, state_next;
  logic [1:0]   sh_reg;
  logic [11:0]  acc_reg;
  logic         rd_en_d_reg;
  logic [7:0]   wr_data_reg;

  logic         carga, fim_bloco, fim_quadro;
  logic [11:0]  acc_sum, media;

  assign carga = (state_reg == OCIOSO) && start;

  zoom_out_gerador_end #(
    .LARGURA (LARGURA),
    .ALTURA  (ALTURA),
    .AW      (AW)
  ) u_gerador (
    .clk           (clk),
    .reset         (reset),
    .carga         (carga),
    .passo_leitura (state_reg == LEITURA),
    .prep_escrita  (state_reg == ESPERA),
    .prox_pixel    (state_reg == ESCRITA),
    .sh            (sh_reg),
    .rd_addr       (rd_addr),
    .wr_addr       (wr_addr),
    .fim_bloco     (fim_bloco),
    .fim_quadro    (fim_quadro)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO:  if (start) state_next = LEITURA;
      LEITURA: if (fim_bloco) state_next = ESPERA;
      ESPERA:  state_next = ESCRITA;
      ESCRITA: state_next = fim_quadro ? FIM : LEITURA;
      FIM:     state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  // The final read of a block is still in flight during ESPERA, so the
  // average is taken from the sum including the current rd_data.
  assign acc_sum = acc_reg + {4'd0, rd_data};
  assign media   = acc_sum >> {sh_reg, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= OCIOSO;
      sh_reg      <= '0;
      acc_reg     <= '0;
      rd_en_d_reg <= 1'b0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rd_en_d_reg <= (state_reg == LEITURA);
      if (carga) begin
        sh_reg <= fator_para_shift(fator_zoom);
      end
      if (carga || ((state_reg == ESCRITA) && !fim_quadro)) begin
        acc_reg <= '0;
      end else if (rd_en_d_reg) begin
        acc_reg <= acc_sum;
      end
      if (state_reg == ESPERA) begin
        wr_data_reg <= media[7:0];
      end
    end
  end

  assign rd_en   = (state_reg == LEITURA);
  assign wr_en   = (state_reg == ESCRITA);
  assign wr_data = wr_data_reg;
  assign busy    = (state_reg != OCIOSO);
  assign done    = (state_reg == FIM);

endmodule
